// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump path: frame states, frame delimiters and frame length.
package debug_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHeader,
    StPc,
    StCyc,
    StRegRd,
    StRegLat,
    StRegSend,
    StTrailer,
    StDone
  } dump_state_e;

  localparam logic [7:0]  FrameHdr = 8'hA5;
  localparam logic [7:0]  FrameTrl = 8'h5A;
  localparam int unsigned DefLen   = 32;
  localparam int unsigned DefNregs = 32;

  // Header + PC + CYCLES + registers + trailer, in bytes.
  function automatic int unsigned frame_len(input int unsigned len, input int unsigned nregs);
    return 2 + (2 + nregs) * (len / 8);
  endfunction

  localparam int unsigned FrameLen = frame_len(DefLen, DefNregs);

endpackage

// File: rtl/debug_dump_tx_if.sv
// Byte stream handshake from the dump engine to the UART transmitter.
interface debug_dump_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/byte_serializer.sv
// Holds one word and exposes it a byte at a time, least significant byte first.
module byte_serializer #(
  parameter int unsigned Len = 32
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           load_i,
  input  logic [Len-1:0] word_i,
  input  logic           shift_i,
  output logic [7:0]     byte_o
);

  logic [Len-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = word_i;
    end else if (shift_i) begin
      sh_d = sh_q >> 8;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign byte_o = sh_q[7:0];

endmodule

// File: rtl/debug_dump_tx.sv
// On halt, snapshots PC and cycle count, walks the register file and streams a framed byte dump.
module debug_dump_tx import debug_pkg::*; #(
  parameter int unsigned LEN   = DefLen,
  parameter int unsigned NREGS = DefNregs,
  parameter logic [7:0]  HDR   = FrameHdr,
  parameter logic [7:0]  TRL   = FrameTrl,
  localparam int unsigned Bytes = LEN / 8,
  localparam int unsigned AW    = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int unsigned BW    = (Bytes > 1) ? $clog2(Bytes) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                halt,
  input  logic [LEN-1:0]      pc,
  input  logic [LEN-1:0]      cycles,
  output logic [AW-1:0]       rf_addr,
  input  logic [LEN-1:0]      rf_data,
  debug_dump_tx_if.master     tx,
  output logic                busy,
  output logic                done
);

  dump_state_e    state_q, state_d;
  logic           armed_q, armed_d;
  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] cyc_q, cyc_d;
  logic [AW-1:0]  reg_idx_q, reg_idx_d;
  logic [BW-1:0]  byte_idx_q, byte_idx_d;
  logic           tx_valid_q, tx_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           ser_load, ser_shift, xfer, last_byte;
  logic [LEN-1:0] ser_word;
  logic [7:0]     ser_byte;

  byte_serializer #(
    .Len (LEN)
  ) u_ser (
    .clk_i   (clk),
    .rst_ni  (reset),
    .load_i  (ser_load),
    .word_i  (ser_word),
    .shift_i (ser_shift),
    .byte_o  (ser_byte)
  );

  assign xfer      = tx_valid_q & tx.tx_ready;
  assign last_byte = (byte_idx_q == BW'(Bytes - 1));

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | ~halt;
    pc_d       = pc_q;
    cyc_d      = cyc_q;
    reg_idx_d  = reg_idx_q;
    byte_idx_d = byte_idx_q;
    tx_valid_d = tx_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_word   = rf_data;

    // Common byte stepping inside a multi-byte field.
    if (xfer && !last_byte &&
        (state_q == StPc || state_q == StCyc || state_q == StRegSend)) begin
      ser_shift  = 1'b1;
      byte_idx_d = byte_idx_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (halt && armed_q) begin
          pc_d      = pc;
          cyc_d     = cycles;
          armed_d   = 1'b0;
          busy_d    = 1'b1;
          reg_idx_d = '0;
          state_d   = StHeader;
        end
      end
      StHeader: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
        end else if (xfer) begin
          ser_load   = 1'b1;
          ser_word   = pc_q;
          byte_idx_d = '0;
          state_d    = StPc;
        end
      end
      StPc: begin
        if (xfer && last_byte) begin
          ser_load   = 1'b1;
          ser_word   = cyc_q;
          byte_idx_d = '0;
          state_d    = StCyc;
        end
      end
      StCyc: begin
        if (xfer && last_byte) begin
          byte_idx_d = '0;
          tx_valid_d = 1'b0;
          reg_idx_d  = '0;
          state_d    = StRegRd;
        end
      end
      StRegRd: state_d = StRegLat;
      StRegLat: begin
        ser_load   = 1'b1;
        tx_valid_d = 1'b1;
        state_d    = StRegSend;
      end
      StRegSend: begin
        if (xfer && last_byte) begin
          byte_idx_d = '0;
          if (reg_idx_q == AW'(NREGS - 1)) begin
            state_d = StTrailer;
          end else begin
            reg_idx_d  = reg_idx_q + 1'b1;
            tx_valid_d = 1'b0;
            state_d    = StRegRd;
          end
        end
      end
      StTrailer: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          state_d    = StDone;
        end
      end
      StDone: begin
        reg_idx_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      armed_q    <= 1'b1;
      pc_q       <= '0;
      cyc_q      <= '0;
      reg_idx_q  <= '0;
      byte_idx_q <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      pc_q       <= pc_d;
      cyc_q      <= cyc_d;
      reg_idx_q  <= reg_idx_d;
      byte_idx_q <= byte_idx_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    tx.tx_data = 8'h00;
    if (tx_valid_q) begin
      unique case (state_q)
        StHeader:  tx.tx_data = HDR;
        StTrailer: tx.tx_data = TRL;
        default:   tx.tx_data = ser_byte;
      endcase
    end
  end

  assign tx.tx_valid = tx_valid_q;
  assign rf_addr     = reg_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Scoreboard bench for debug_dump_tx: expected frames are queued at halt, a monitor checks bytes.
module tb_debug_dump_tx;

  logic        clk;
  logic        rst_n;
  logic        halt;
  logic [31:0] pc;
  logic [31:0] cycles;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        busy;
  logic        done;

  logic [31:0] regs [32];
  logic [7:0]  sb [$];

  int n_cmp    = 0;
  int n_err    = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  bit rand_ready = 0;

  debug_dump_tx_if tx_if ();

  debug_dump_tx u_dut (
    .clk     (clk),
    .reset   (rst_n),
    .halt    (halt),
    .pc      (pc),
    .cycles  (cycles),
    .rf_addr (rf_addr),
    .rf_data (rf_data),
    .tx      (tx_if),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read register file model.
  always @(posedge clk) rf_data <= regs[rf_addr];

  initial begin
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_if.tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame as defined: header, PC, CYCLES, R0..R31 (each LSB first), trailer.
  task automatic push_frame(input logic [31:0] p, input logic [31:0] c);
    sb.push_back(8'hA5);
    for (int i = 0; i < 4; i++) sb.push_back(p[8*i +: 8]);
    for (int i = 0; i < 4; i++) sb.push_back(c[8*i +: 8]);
    for (int r = 0; r < 32; r++) begin
      logic [31:0] w;
      w = regs[r];
      for (int i = 0; i < 4; i++) sb.push_back(w[8*i +: 8]);
    end
    sb.push_back(8'h5A);
  endtask

  task automatic wait_frame(input string name, input int budget);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: no done after %0d cycles, %0d bytes pending", name, k, sb.size());
    end else begin
      repeat (5) @(posedge clk);
      check({name, "_bytes_left"}, sb.size(), 0);
      check({name, "_done_pulses"}, done_cnt - d0, 1);
    end
  endtask

  task automatic wait_addr(input logic [4:0] a, input string name);
    int k;
    k = 0;
    while (rf_addr < a && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_reached_addr"}, {31'd0, rf_addr >= a}, 1);
  endtask

  // Monitor: byte compare on every transfer, plus hold-stability and done/busy checks.
  initial begin
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    prev_stall = 0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) begin
          check("hold_valid", {31'd0, tx_if.tx_valid}, 1);
          check("hold_data", {24'd0, tx_if.tx_data}, {24'd0, prev_data});
        end
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          xfer_cnt++;
          check("busy_during_xfer", {31'd0, busy}, 1);
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %h expected no transfer", tx_if.tx_data);
          end else begin
            exp = sb.pop_front();
            check("frame_byte", {24'd0, tx_if.tx_data}, {24'd0, exp});
          end
        end
        if (done) begin
          done_cnt++;
          check("busy_at_done", {31'd0, busy}, 0);
        end
        prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
        prev_data  = tx_if.tx_data;
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int d0;
    rst_n  = 1'b0;
    halt   = 1'b0;
    pc     = 32'h0000_0040;
    cycles = 32'h0000_0123;
    for (int r = 0; r < 32; r++) regs[r] = r * 32'h0101_0101;

    // 1: reset values, then silence with halt low.
    #4;
    check("rst_tx_valid", {31'd0, tx_if.tx_valid}, 0);
    check("rst_tx_data", {24'd0, tx_if.tx_data}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_rf_addr", {27'd0, rf_addr}, 0);
    #4 rst_n = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("idle_no_bytes", xfer_cnt, 0);
    check("idle_busy", {31'd0, busy}, 0);

    // 2: one-cycle halt pulse, ready held high.
    halt = 1'b1;
    push_frame(pc, cycles);
    @(posedge clk);
    #1 halt = 1'b0;
    wait_frame("t2", 2000);

    // 3: same data with sparse ready, then random data.
    rand_ready = 1;
    repeat (3) @(posedge clk);
    #1 halt = 1'b1;
    push_frame(pc, cycles);
    @(posedge clk);
    #1 halt = 1'b0;
    wait_frame("t3a", 4000);
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    pc     = $urandom;
    cycles = $urandom;
    repeat (3) @(posedge clk);
    #1 halt = 1'b1;
    push_frame(pc, cycles);
    @(posedge clk);
    #1 halt = 1'b0;
    wait_frame("t3b", 4000);
    rand_ready = 0;

    // 4: inputs change and halt drops mid-dump; no refire until halt rises again.
    pc     = 32'h0000_0040;
    cycles = 32'h0000_0123;
    @(posedge clk);
    #1 halt = 1'b1;
    push_frame(pc, cycles);
    wait_addr(5'd3, "t4");
    pc     = 32'hDEAD_BEEF;
    cycles = 32'h0BAD_F00D;
    halt   = 1'b0;
    wait_frame("t4", 2000);
    x0 = xfer_cnt;
    repeat (50) @(posedge clk);
    check("t4_no_refire", xfer_cnt, x0);
    #1 halt = 1'b1;
    push_frame(pc, cycles);
    wait_frame("t4b", 2000);
    #1 halt = 1'b0;
    repeat (5) @(posedge clk);

    // 5: reset after R5 with halt held; fresh frame after release.
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
    pc = $urandom;
    #1 halt = 1'b1;
    push_frame(pc, cycles);
    wait_addr(5'd6, "t5");
    begin
      int k;
      k = 0;
      while (!tx_if.tx_valid && k < 20) begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("t5_valid_before_rst", {31'd0, tx_if.tx_valid}, 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("t5_valid_async_clr", {31'd0, tx_if.tx_valid}, 0);
    check("t5_busy_clr", {31'd0, busy}, 0);
    repeat (3) @(posedge clk);
    #3;
    push_frame(pc, cycles);
    rst_n = 1'b1;
    wait_frame("t5", 2000);

    // 6: halt stays high for two more frame lengths.
    x0 = xfer_cnt;
    d0 = done_cnt;
    repeat (300) @(posedge clk);
    check("t6_no_extra_bytes", xfer_cnt, x0);
    check("t6_no_extra_done", done_cnt, d0);
    #1 halt = 1'b0;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
